// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and the data port (DM).
// The arbiter uses fixed DM priority with a starvation guard for IF.
// An in-order tracking FIFO routes each response back to the port that issued the request.
// Fetch responses made stale by a pipeline flush are dropped.
module mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_resp_valid,
    input  logic        if_resp_ready,
    output logic [31:0] if_resp_data,
    input  logic        dm_req_valid,
    output logic        dm_req_ready,
    input  logic [31:0] dm_req_addr,
    input  logic [31:0] dm_req_wdata,
    input  logic        dm_req_we,
    input  logic [3:0]  dm_req_be,
    output logic        dm_resp_valid,
    input  logic        dm_resp_ready,
    output logic [31:0] dm_resp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic        mem_req_we,
    output logic [3:0]  mem_req_be,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_resp_data,
    input  logic        flush
);
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned StW  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic PortIf = 1'b0;
    localparam logic PortDm = 1'b1;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            lock_valid_q, lock_valid_d;
    logic            lock_id_q, lock_id_d;
    logic [StW-1:0]  starve_cnt_q, starve_cnt_d;
    logic            fifo_id_q [MAX_OUTSTANDING];
    logic            fifo_id_d [MAX_OUTSTANDING];
    logic            fifo_discard_q [MAX_OUTSTANDING];
    logic            fifo_discard_d [MAX_OUTSTANDING];

    logic full, empty, sel_id, sel_valid, grant, pop, head_id, head_discard;

    // Arbitration, request muxing and ready generation
    always_comb begin
        full  = (count_q == CntW'(MAX_OUTSTANDING));
        empty = (count_q == '0);
        if (lock_valid_q) begin
            sel_id = lock_id_q;
        end else if (dm_req_valid &&
                     !(if_req_valid && (starve_cnt_q == StW'(STARVE_LIMIT)))) begin
            sel_id = PortDm;
        end else begin
            sel_id = PortIf;
        end
        sel_valid     = (sel_id == PortDm) ? dm_req_valid : if_req_valid;
        mem_req_valid = !rst && sel_valid && !full;
        grant         = mem_req_valid && mem_req_ready;
        if_req_ready  = !rst && (sel_id == PortIf) && mem_req_ready && !full;
        dm_req_ready  = !rst && (sel_id == PortDm) && mem_req_ready && !full;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_we    = 1'b0;
        mem_req_be    = '0;
        if (!rst) begin
            if (sel_id == PortDm) begin
                mem_req_addr  = dm_req_addr;
                mem_req_wdata = dm_req_wdata;
                mem_req_we    = dm_req_we;
                mem_req_be    = dm_req_be;
            end else begin
                mem_req_addr = if_req_addr;
                mem_req_be   = 4'hF;
            end
        end
    end

    // Response routing from the head of the tracking FIFO
    always_comb begin
        head_id        = fifo_id_q[rd_ptr_q];
        head_discard   = fifo_discard_q[rd_ptr_q];
        if_resp_valid  = 1'b0;
        dm_resp_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        if (!empty && !rst) begin
            if (head_discard) begin
                mem_resp_ready = 1'b1;
            end else if (head_id == PortIf) begin
                // A response landing in a flush cycle is stale and swallowed here
                if_resp_valid  = mem_resp_valid && !flush;
                mem_resp_ready = if_resp_ready || flush;
            end else begin
                dm_resp_valid  = mem_resp_valid;
                mem_resp_ready = dm_resp_ready;
            end
        end
        if_resp_data = mem_resp_data;
        dm_resp_data = mem_resp_data;
        pop          = mem_resp_valid && mem_resp_ready;
    end

    // Next-state for the tracking FIFO, lock and starvation counter
    always_comb begin
        fifo_id_d      = fifo_id_q;
        fifo_discard_d = fifo_discard_q;
        if (flush) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                if (fifo_id_q[i] == PortIf) fifo_discard_d[i] = 1'b1;
            end
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (grant) begin
            fifo_id_d[wr_ptr_q]      = sel_id;
            fifo_discard_d[wr_ptr_q] = (sel_id == PortIf) && flush;
            wr_ptr_d                 = wr_ptr_q + PtrW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({grant, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        // Hold the selection while downstream stalls so payload stays stable
        lock_valid_d = mem_req_valid && !mem_req_ready;
        lock_id_d    = lock_valid_d ? sel_id : lock_id_q;
        starve_cnt_d = starve_cnt_q;
        if (!if_req_valid || (grant && (sel_id == PortIf))) begin
            starve_cnt_d = '0;
        end else if (grant && (starve_cnt_q != StW'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + StW'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lock_valid_q <= 1'b0;
            lock_id_q    <= PortIf;
            starve_cnt_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_id_q[i]      <= PortIf;
                fifo_discard_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            lock_valid_q   <= lock_valid_d;
            lock_id_q      <= lock_id_d;
            starve_cnt_q   <= starve_cnt_d;
            fifo_id_q      <= fifo_id_d;
            fifo_discard_q <= fifo_discard_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_resp_valid, if_resp_ready;
    logic [31:0] if_resp_data;
    logic        dm_req_valid, dm_req_ready;
    logic [31:0] dm_req_addr, dm_req_wdata;
    logic        dm_req_we;
    logic [3:0]  dm_req_be;
    logic        dm_resp_valid, dm_resp_ready;
    logic [31:0] dm_resp_data;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_req_we;
    logic [3:0]  mem_req_be;
    logic        mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_resp_data;
    logic        flush;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
        .if_resp_data(if_resp_data),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
        .dm_req_wdata(dm_req_wdata), .dm_req_we(dm_req_we), .dm_req_be(dm_req_be),
        .dm_resp_valid(dm_resp_valid), .dm_resp_ready(dm_resp_ready),
        .dm_resp_data(dm_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_we(mem_req_we),
        .mem_req_be(mem_req_be),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_data(mem_resp_data),
        .flush(flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        if_req_valid = 0; if_req_addr = 0; if_resp_ready = 0;
        dm_req_valid = 0; dm_req_addr = 0; dm_req_wdata = 0; dm_req_we = 0; dm_req_be = 0;
        dm_resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        flush = 0;
    endtask

    // Advance to just after the next rising edge
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_dm;
        logic resp_dm;
        idle();
        rst = 1;
        if_req_valid = 1;
        dm_req_valid = 1;
        mem_req_ready = 1;
        #2;
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_if_req_ready", if_req_ready, 0);
        chk("rst_dm_req_ready", dm_req_ready, 0);
        chk("rst_mem_resp_ready", mem_resp_ready, 0);
        nxt();
        idle();
        rst = 0;
        nxt();

        // Both ports valid for 8 cycles, responses 2 cycles after each grant
        for (int k = 0; k < 10; k++) begin
            idle();
            mem_req_ready = 1;
            if_resp_ready = 1;
            dm_resp_ready = 1;
            if (k < 8) begin
                if_req_valid = 1; if_req_addr = 32'h1000;
                dm_req_valid = 1; dm_req_addr = 32'h2000; dm_req_be = 4'hF;
            end
            if (k >= 2) begin
                mem_resp_valid = 1;
                mem_resp_data = 32'hA000_0000 + 32'(k - 2);
            end
            #1;
            exp_dm = ((k % 4) != 3);
            resp_dm = (((k - 2) % 4) != 3);
            if (k < 8) begin
                chk("arb_dm_ready", dm_req_ready, exp_dm);
                chk("arb_if_ready", if_req_ready, !exp_dm);
                chk("arb_addr", mem_req_addr, exp_dm ? 32'h2000 : 32'h1000);
            end
            if (k >= 2) begin
                chk("route_dm_valid", dm_resp_valid, resp_dm);
                chk("route_if_valid", if_resp_valid, !resp_dm);
                chk("route_data", resp_dm ? dm_resp_data : if_resp_data,
                    32'hA000_0000 + 32'(k - 2));
            end
            nxt();
        end
        idle();
        nxt();

        // DM store stalled downstream for 3 cycles while IF arrives
        for (int k = 0; k < 4; k++) begin
            idle();
            dm_req_valid = 1; dm_req_addr = 32'h100; dm_req_wdata = 32'hDEADBEEF;
            dm_req_we = 1; dm_req_be = 4'b0011;
            if_req_valid = (k >= 1); if_req_addr = 32'h3000;
            mem_req_ready = (k == 3);
            #1;
            chk("lock_valid", mem_req_valid, 1);
            chk("lock_addr", mem_req_addr, 32'h100);
            chk("lock_wdata", mem_req_wdata, 32'hDEADBEEF);
            chk("lock_we_be", {mem_req_we, mem_req_be}, 5'b1_0011);
            chk("lock_dm_ready", dm_req_ready, (k == 3));
            chk("lock_if_ready", if_req_ready, 0);
            nxt();
        end
        idle();
        if_req_valid = 1; if_req_addr = 32'h3000; mem_req_ready = 1;
        #1;
        chk("after_lock_if_ready", if_req_ready, 1);
        chk("if_payload", {mem_req_we, mem_req_be, mem_req_wdata}, {1'b0, 4'hF, 32'h0});
        nxt();
        idle();
        mem_resp_valid = 1; mem_resp_data = 32'h0; dm_resp_ready = 1; if_resp_ready = 1;
        #1;
        chk("store_resp_dm", dm_resp_valid, 1);
        chk("store_resp_if", if_resp_valid, 0);
        nxt();
        mem_resp_data = 32'hAAAA;
        #1;
        chk("fetch_resp_if", if_resp_valid, 1);
        chk("fetch_resp_data", if_resp_data, 32'hAAAA);
        nxt();
        idle();
        nxt();

        // Fill the tracking FIFO with IF reads
        for (int k = 0; k < 4; k++) begin
            idle();
            if_req_valid = 1; if_req_addr = 32'h4000 + 32'(4 * k); mem_req_ready = 1;
            #1;
            chk("fill_if_ready", if_req_ready, 1);
            nxt();
        end
        #1;
        chk("full_if_ready", if_req_ready, 0);
        chk("full_mem_req_valid", mem_req_valid, 0);
        nxt();
        mem_resp_valid = 1; mem_resp_data = 32'h77; if_resp_ready = 1;
        #1;
        chk("full_pop_if_ready", if_req_ready, 0);
        chk("full_pop_resp", if_resp_valid, 1);
        nxt();
        #1;
        chk("enq_pop_if_ready", if_req_ready, 1);
        chk("enq_pop_resp", if_resp_valid, 1);
        nxt();
        mem_resp_valid = 0;
        #1;
        chk("refill_if_ready", if_req_ready, 1);
        nxt();
        #1;
        chk("refull_if_ready", if_req_ready, 0);
        nxt();
        if_req_valid = 0;
        mem_resp_valid = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_if_valid", if_resp_valid, 1);
            nxt();
        end
        #1;
        chk("empty_mem_resp_ready", mem_resp_ready, 0);
        chk("empty_if_valid", if_resp_valid, 0);
        nxt();

        // Flush with two IF reads and one DM load in flight
        idle();
        mem_req_ready = 1;
        if_req_valid = 1; if_req_addr = 32'h0;
        nxt();
        if_req_addr = 32'h4;
        nxt();
        if_req_valid = 0;
        dm_req_valid = 1; dm_req_addr = 32'h300; dm_req_be = 4'hF;
        #1;
        chk("flush_dm_grant", dm_req_ready, 1);
        nxt();
        idle();
        flush = 1;
        nxt();
        flush = 0;
        mem_resp_valid = 1; mem_resp_data = 32'hBAD0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("flushed_if_valid", if_resp_valid, 0);
            chk("flushed_mem_ready", mem_resp_ready, 1);
            nxt();
        end
        mem_resp_data = 32'h12345678; dm_resp_ready = 1;
        #1;
        chk("flush_dm_valid", dm_resp_valid, 1);
        chk("flush_dm_data", dm_resp_data, 32'h12345678);
        nxt();
        idle();
        nxt();

        // Flush coinciding with an IF grant and the head IF response
        mem_req_ready = 1;
        if_req_valid = 1; if_req_addr = 32'h40;
        nxt();
        if_req_addr = 32'h44;
        mem_resp_valid = 1; mem_resp_data = 32'h55; if_resp_ready = 1; flush = 1;
        #1;
        chk("sameflush_if_valid", if_resp_valid, 0);
        chk("sameflush_mem_ready", mem_resp_ready, 1);
        chk("sameflush_grant", if_req_ready, 1);
        nxt();
        idle();
        mem_resp_valid = 1;
        #1;
        chk("newentry_if_valid", if_resp_valid, 0);
        chk("newentry_discard", mem_resp_ready, 1);
        nxt();
        #1;
        chk("sameflush_empty", mem_resp_ready, 0);
        nxt();
        idle();

        // Asynchronous reset with 3 entries outstanding
        mem_req_ready = 1;
        if_req_valid = 1; if_req_addr = 32'h500;
        for (int k = 0; k < 3; k++) nxt();
        dm_req_valid = 1; dm_req_addr = 32'h600;
        mem_resp_valid = 1; if_resp_ready = 1;
        #1;
        chk("pre_rst_mem_ready", mem_resp_ready, 1);
        #1;
        rst = 1;
        #1;
        chk("arst_mem_req_valid", mem_req_valid, 0);
        chk("arst_readys", {if_req_ready, dm_req_ready}, 2'b00);
        chk("arst_resp", {if_resp_valid, dm_resp_valid, mem_resp_ready}, 3'b000);
        chk("arst_addr", mem_req_addr, 0);
        nxt();
        rst = 0;
        if_req_valid = 0;
        #1;
        chk("post_rst_count0", mem_resp_ready, 0);
        chk("post_rst_dm_grant", dm_req_ready, 1);
        chk("post_rst_addr", mem_req_addr, 32'h600);
        nxt();
        idle();
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
